// File: rtl/instr_encoder.sv
// MIPS instruction encoder with a session FSM and an output FIFO.
// Field sets (R/I/J formats) are packed into 32-bit words. Each word is tagged
// with a running word address and queued for a ready/valid consumer.
module instr_encoder #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rest,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [1:0]  fmt,
  input  logic [5:0]  op,
  input  logic [4:0]  rs,
  input  logic [4:0]  rt,
  input  logic [4:0]  rd,
  input  logic [4:0]  shamt,
  input  logic [5:0]  funct,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_word,
  output logic [31:0] out_addr,
  output logic        busy,
  output logic        done,
  output logic [7:0]  err_cnt
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [31:0] BREAK_WORD = 32'h0000_000D;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_pc;
  logic [7:0]      r_err_cnt;
  logic [31:0]     r_mem_word [FIFO_DEPTH];
  logic [31:0]     r_mem_addr [FIFO_DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  logic            w_push;
  logic            w_pop;
  logic            w_done;
  logic            w_illegal;
  logic [31:0]     w_enc_word;

  // Pack one field set; an illegal format becomes a break instruction.
  function automatic logic [31:0] encode(
    input logic [1:0]  f,
    input logic [5:0]  f_op,
    input logic [4:0]  f_rs,
    input logic [4:0]  f_rt,
    input logic [4:0]  f_rd,
    input logic [4:0]  f_shamt,
    input logic [5:0]  f_funct,
    input logic [15:0] f_imm,
    input logic [25:0] f_target
  );
    logic [31:0] w;
    case (f)
      2'd0:    w = {6'b000000, f_rs, f_rt, f_rd, f_shamt, f_funct};
      2'd1:    w = {f_op, f_rs, f_rt, f_imm};
      2'd2:    w = {f_op, f_target};
      default: w = BREAK_WORD;
    endcase
    return w;
  endfunction

  // Increment that sticks at the all-ones value instead of wrapping.
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign w_illegal  = (fmt == 2'd3);
  assign w_enc_word = encode(fmt, op, rs, rt, rd, shamt, funct, imm, target);

  // The "not full" test uses the count before the edge, so a full FIFO
  // that is popping this cycle still refuses a push.
  assign in_ready  = (r_state == S_RUN) && (r_count < CW'(FIFO_DEPTH));
  assign out_valid = (r_count != '0);
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign out_word  = out_valid ? r_mem_word[r_rptr] : 32'h0;
  assign out_addr  = out_valid ? r_mem_addr[r_rptr] : 32'h0;
  assign busy      = (r_state != S_IDLE);
  assign done      = w_done;
  assign err_cnt   = r_err_cnt;

  // Next-state logic; done fires in the first DRAIN cycle that sees an empty FIFO.
  always_comb begin
    w_state_nxt = r_state;
    w_done      = 1'b0;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_push && in_last) w_state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (r_count == '0) begin
          w_done      = 1'b1;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Control state: FSM, address counter, error counter and FIFO pointers.
  always_ff @(posedge clk) begin
    if (rest) begin
      r_state   <= S_IDLE;
      r_pc      <= 32'h0;
      r_err_cnt <= 8'h0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == S_IDLE) && start) begin
        r_pc      <= base_addr & 32'hFFFF_FFFC;
        r_err_cnt <= 8'h0;
      end else if (w_push) begin
        r_pc <= r_pc + 32'd4;
        if (w_illegal) r_err_cnt <= sat_inc(r_err_cnt);
      end
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage is left unreset; output gating hides stale entries.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_word[r_wptr] <= w_enc_word;
      r_mem_addr[r_wptr] <= r_pc;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios and randomized
// sessions, compared cycle by cycle against a queue-based session model.
module tb_instr_encoder;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rest = 1'b1;
  logic        start = 1'b0;
  logic [31:0] base_addr = '0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic        in_last = 1'b0;
  logic [1:0]  fmt = '0;
  logic [5:0]  op = '0;
  logic [4:0]  rs = '0, rt = '0, rd = '0, shamt = '0;
  logic [5:0]  funct = '0;
  logic [15:0] imm = '0;
  logic [25:0] target = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_word, out_addr;
  logic        busy, done;
  logic [7:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] w;
    logic [31:0] a;
  } ent_t;

  ent_t        q[$];
  bit          m_active, m_drain, m_acc;
  logic [31:0] m_pc;
  int          m_err;

  instr_encoder #(.FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rest(rest), .start(start), .base_addr(base_addr),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last), .fmt(fmt),
    .op(op), .rs(rs), .rt(rt), .rd(rd), .shamt(shamt), .funct(funct),
    .imm(imm), .target(target), .out_valid(out_valid), .out_ready(out_ready),
    .out_word(out_word), .out_addr(out_addr), .busy(busy), .done(done),
    .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Reference encoding from field positions, with plain shifts and adds.
  function automatic logic [31:0] ref_word();
    case (fmt)
      2'd0: return (32'(rs) << 21) + (32'(rt) << 16) + (32'(rd) << 11)
                  + (32'(shamt) << 6) + 32'(funct);
      2'd1: return (32'(op) << 26) + (32'(rs) << 21) + (32'(rt) << 16) + 32'(imm);
      2'd2: return (32'(op) << 26) + 32'(target);
      default: return 32'd13;
    endcase
  endfunction

  // Compare outputs against the model, then advance model and DUT by one edge.
  task automatic cyc();
    int n = q.size();
    bit exp_done = m_active && m_drain && (n == 0);
    bit pop, push;
    check("in_ready", in_ready, m_active && !m_drain && (n < DEPTH));
    check("out_valid", out_valid, n > 0);
    check("out_word", out_word, (n > 0) ? q[0].w : 32'h0);
    check("out_addr", out_addr, (n > 0) ? q[0].a : 32'h0);
    check("busy", busy, m_active);
    check("done", done, exp_done);
    check("err_cnt", err_cnt, m_err);
    m_acc = 0;
    if (rest) begin
      m_active = 0; m_drain = 0; q.delete(); m_pc = 0; m_err = 0;
    end else if (!m_active) begin
      if (start) begin
        m_active = 1; m_pc = {base_addr[31:2], 2'b00}; m_err = 0;
      end
    end else begin
      pop  = (n > 0) && out_ready;
      push = !m_drain && in_valid && (n < DEPTH);
      if (exp_done) begin m_active = 0; m_drain = 0; end
      if (pop) void'(q.pop_front());
      if (push) begin
        q.push_back('{w: ref_word(), a: m_pc});
        if (fmt == 2'd3 && m_err < 255) m_err++;
        m_pc = m_pc + 32'd4;
        if (in_last) m_drain = 1;
        m_acc = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rand_fields();
    op = 6'($urandom); rs = 5'($urandom); rt = 5'($urandom); rd = 5'($urandom);
    shamt = 5'($urandom); funct = 6'($urandom); imm = 16'($urandom);
    target = 26'($urandom);
  endtask

  // Hold one field set until accepted; optionally jiggle out_ready/start.
  task automatic send(input logic [1:0] f, input bit last, input bit jiggle);
    fmt = f; in_last = last; in_valid = 1'b1;
    for (int k = 0; k < 200; k++) begin
      if (jiggle) begin
        out_ready = 1'($urandom);
        start = ($urandom_range(0, 7) == 0);
      end
      cyc();
      if (m_acc) break;
    end
    check("send_accepted", m_acc, 1);
    in_valid = 1'b0; in_last = 1'b0; start = 1'b0;
  endtask

  task automatic begin_session(input logic [31:0] addr);
    base_addr = addr; start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic finish_session();
    out_ready = 1'b1;
    for (int k = 0; k < 200 && m_active; k++) cyc();
    check("session_end", m_active, 0);
  endtask

  initial begin
    m_active = 0; m_drain = 0; m_pc = 0; m_err = 0;
    @(posedge clk);
    @(negedge clk);
    cyc();
    cyc();
    rest = 1'b0;
    cyc();

    // Single R-format word, visible one cycle after acceptance.
    begin_session(32'h0040_0000);
    rs = 5'd1; rt = 5'd2; rd = 5'd3; shamt = 5'd0; funct = 6'h20; op = 6'h3F;
    send(2'd0, 1'b1, 1'b0);
    check("r_word", out_word, 32'h0022_1820);
    check("r_addr", out_addr, 32'h0040_0000);
    finish_session();

    // I then J with a consumer that is always ready.
    out_ready = 1'b1;
    begin_session(32'h0040_0000);
    op = 6'h08; rs = 5'd0; rt = 5'd8; imm = 16'h0005;
    send(2'd1, 1'b0, 1'b0);
    check("i_word", out_word, 32'h2008_0005);
    check("i_addr", out_addr, 32'h0040_0000);
    op = 6'h02; target = 26'h010_0000;
    send(2'd2, 1'b1, 1'b0);
    check("j_word", out_word, 32'h0810_0000);
    check("j_addr", out_addr, 32'h0040_0004);
    finish_session();
    check("ij_idle", busy, 0);

    // Backpressure: four fill the FIFO, the fifth waits until the consumer drains.
    out_ready = 1'b0;
    begin_session(32'h0000_1000);
    for (int i = 0; i < 4; i++) begin rand_fields(); send(2'($urandom_range(0, 2)), 1'b0, 1'b0); end
    rand_fields(); fmt = 2'd1; in_valid = 1'b1;
    check("full_in_ready", in_ready, 0);
    cyc();
    check("full_no_accept", m_acc, 0);
    out_ready = 1'b1;
    send(2'd1, 1'b0, 1'b0);
    rand_fields();
    send(2'd0, 1'b1, 1'b0);
    finish_session();

    // Illegal formats produce break words and bump the error count.
    begin_session(32'h0000_2000);
    send(2'd3, 1'b0, 1'b0);
    check("brk_word", out_word, 32'h0000_000D);
    send(2'd3, 1'b1, 1'b0);
    finish_session();
    check("err_two", err_cnt, 8'd2);
    begin_session(32'h0000_3000);
    check("err_cleared", err_cnt, 8'd0);
    send(2'd0, 1'b1, 1'b0);
    finish_session();

    // Address wraps past the top of the address space.
    out_ready = 1'b0;
    begin_session(32'hFFFF_FFFB);
    for (int i = 0; i < 3; i++) begin rand_fields(); send(2'd2, i == 2, 1'b0); end
    check("wrap_first", out_addr, 32'hFFFF_FFF8);
    finish_session();

    // Reset in DRAIN with three buffered words discards them silently.
    out_ready = 1'b0;
    begin_session(32'h0000_4000);
    for (int i = 0; i < 3; i++) begin rand_fields(); send(2'd1, i == 2, 1'b0); end
    rest = 1'b1; out_ready = 1'b1; start = 1'b1; in_valid = 1'b1;
    cyc();
    rest = 1'b0; start = 1'b0; in_valid = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    for (int i = 0; i < 3; i++) cyc();

    // Error counter saturates at 255.
    out_ready = 1'b1;
    begin_session(32'h0000_5000);
    for (int i = 0; i < 260; i++) send(2'd3, i == 259, 1'b0);
    finish_session();
    check("err_sat", err_cnt, 8'd255);

    // Randomized sessions with random backpressure, gaps and stray starts.
    for (int s = 0; s < 8; s++) begin
      int n = $urandom_range(1, 12);
      begin_session($urandom);
      for (int i = 0; i < n; i++) begin
        if ($urandom_range(0, 3) == 0) begin
          out_ready = 1'($urandom);
          cyc();
        end
        rand_fields();
        send(2'($urandom), i == n - 1, 1'b1);
      end
      for (int k = 0; k < 200 && m_active; k++) begin
        out_ready = 1'($urandom);
        start = 1'($urandom);
        cyc();
      end
      start = 1'b0;
      check("rand_session_end", m_active, 0);
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, output buffer depth in words (power of 2, 2..16).
REQ-002 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-003 SHALL have port rest, input, 1, reset; synchronous, active-high.
REQ-004 SHALL have port start, input, 1, one-cycle pulse that begins an encode session.
REQ-005 SHALL have port base_addr, input, 32, first word address of a session (bits[1:0] ignored, treated as 0).
REQ-006 SHALL have port in_valid, input, 1, field set present.
REQ-007 SHALL have port in_ready, output, 1, field set accepted this cycle if in_valid high.
REQ-008 SHALL have port in_last, input, 1, marks the final field set of the session.
REQ-009 SHALL have port fmt, input, 2, 0=R, 1=I, 2=J, 3=illegal.
REQ-010 SHALL have ports op (6), rs (5), rt (5), rd (5), shamt (5), funct (6), imm (16), target (26), all inputs, MIPS instruction fields.
REQ-011 SHALL have port out_valid, output, 1, FIFO head valid.
REQ-012 SHALL have port out_ready, input, 1, consumer takes head word.
REQ-013 SHALL have port out_word, output, 32, encoded instruction.
REQ-014 SHALL have port out_addr, output, 32, word address tagged to out_word.
REQ-015 SHALL have port busy, output, 1, high in RUN or DRAIN.
REQ-016 SHALL have port done, output, 1, one-cycle pulse when session completes.
REQ-017 SHALL have port err_cnt, output, 8, count of illegal field sets in current session.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, DRAIN.
REQ-019 IDLE: start -> pc <= {base_addr[31:2],2'b00}, err_cnt <= 0, next state RUN; in_valid ignored in IDLE.
REQ-020 RUN: in_ready = (FIFO count < FIFO_DEPTH); in_ready SHALL be 0 in IDLE and DRAIN.
REQ-021 Accept (in_valid & in_ready): encoded word and current pc pushed to FIFO same edge; pc <= pc + 4, wrapping modulo 2^32 (0xFFFFFFFC -> 0x00000000).
REQ-022 Accept with in_last=1: next state DRAIN.
REQ-023 DRAIN: when FIFO empty (including a pop emptying it this cycle, checked next cycle), done=1 for exactly one cycle, next state IDLE.
REQ-024 Encoding: R -> {6'b000000, rs, rt, rd, shamt, funct} (op input ignored); I -> {op, rs, rt, imm}; J -> {op, target}.
REQ-025 fmt=3: word 0x0000000D (break) pushed, err_cnt increments, saturating at 255.
REQ-026 Latency: word accepted at edge N appears at out_word/out_valid after edge N when FIFO was empty (one cycle).
REQ-027 out_valid = FIFO not empty; pop on out_valid & out_ready; out_word/out_addr stable while out_valid & !out_ready.
REQ-028 Simultaneous push and pop SHALL keep count unchanged and preserve order; full FIFO with pop SHALL not accept a push that cycle (in_ready from pre-edge count).
REQ-029 start in RUN or DRAIN SHALL be ignored.
REQ-030 out_word/out_addr SHALL be 0 when out_valid=0.

Reset
REQ-031 rest=1 at an edge SHALL set state IDLE, FIFO empty, pc=0, err_cnt=0; outputs in_ready=0, out_valid=0, out_word=0, out_addr=0, busy=0, done=0.
REQ-032 rest SHALL override start, in_valid and out_ready the same cycle; reset mid-session discards buffered words with no done pulse.

Verification
REQ-033 start base 0x00400000; R rs=1 rt=2 rd=3 shamt=0 funct=0x20 -> out_word 0x00221820, out_addr 0x00400000 one cycle later.
REQ-034 I op=0x08 rs=0 rt=8 imm=0x0005 then J op=0x02 target=0x0100000 (in_last) with out_ready=1 -> 0x20080005 @0x00400000, 0x08100000 @0x00400004, done pulse, return IDLE.
REQ-035 out_ready=0, push 6 field sets -> in_ready low after 4 accepted; raise out_ready -> words drain in order, remaining 2 accepted.
REQ-036 fmt=3 twice then in_last -> two 0x0000000D words, err_cnt=2; next start clears err_cnt to 0.
REQ-037 base_addr 0xFFFFFFF8, three words -> addrs 0xFFFFFFF8, 0xFFFFFFFC, 0x00000000.
REQ-038 rest asserted with 3 words buffered in DRAIN -> next cycle out_valid=0, busy=0, no done pulse.
